// File: rtl/multdiv_issuer.sv
// Execute-stage initiator for the multdiv unit: latches operands, pulses the
// start strobe, stalls the pipeline until completion and emits one writeback.
module multdiv_issuer #(
  parameter int TIMEOUT       = 64,
  parameter int MULT_EXC_CODE = 4,
  parameter int DIV_EXC_CODE  = 5,
  parameter int EXC_REG       = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_is_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  op_rd,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  input  logic [31:0] data_result,
  input  logic        data_exception,
  input  logic        data_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic [1:0]  dbg_state_o
);

  // Handshake: op_valid is a request that is only looked at in IDLE; stall is
  // its back-pressure and stays high from the accepting cycle until DONE, so
  // the pipeline presents the next instruction only after the writeback.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [7:0]  WD_LAST   = 8'(TIMEOUT - 1);
  localparam logic [4:0]  EXC_RD    = 5'(EXC_REG);
  localparam logic [31:0] MULT_CODE = 32'(MULT_EXC_CODE);
  localparam logic [31:0] DIV_CODE  = 32'(DIV_EXC_CODE);

  state_e      state_q;
  logic        ctrl_mult_q;
  logic        ctrl_div_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic        is_div_q;
  logic [4:0]  rd_q;
  logic [7:0]  wdog_q;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic [31:0] exc_code;

  assign exc_code = is_div_q ? DIV_CODE : MULT_CODE;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      is_div_q    <= 1'b0;
      rd_q        <= '0;
      wdog_q      <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (op_valid) begin
            opa_q       <= op_a;
            opb_q       <= op_b;
            is_div_q    <= op_is_div;
            rd_q        <= op_rd;
            ctrl_div_q  <= op_is_div;
            ctrl_mult_q <= !op_is_div;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A RDY seen here may belong to the previous operation, so ignore it.
          wdog_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          wdog_q <= wdog_q + 8'd1;
          if (data_resultRDY) begin
            wb_valid_q <= 1'b1;
            state_q    <= S_DONE;
            if (data_exception) begin
              wb_rd_q   <= EXC_RD;
              wb_data_q <= exc_code;
            end else begin
              wb_rd_q   <= rd_q;
              wb_data_q <= data_result;
            end
          end else if (wdog_q == WD_LAST) begin
            wb_valid_q <= 1'b1;
            wb_rd_q    <= EXC_RD;
            wb_data_q  <= exc_code;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ctrl_MULT     = ctrl_mult_q;
  assign ctrl_DIV      = ctrl_div_q;
  assign data_operandA = opa_q;
  assign data_operandB = opb_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign busy          = (state_q != S_IDLE);
  assign stall         = ((state_q == S_IDLE) && op_valid) ||
                         (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_multdiv_issuer.sv
// Randomized bench for multdiv_issuer: the bench plays the multdiv unit and
// predicts each writeback and its timing from an arithmetic model.
module tb_multdiv_issuer;

  localparam int TO = 8;
  localparam longint MAXI = 64'sh0000_0000_7FFF_FFFF;
  localparam longint MINI = -64'sh0000_0000_8000_0000;

  logic        clock;
  logic        reset;
  logic        op_valid;
  logic        op_is_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  op_rd;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;
  logic [1:0]  dbg_state_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [36:0] exp_q[$];

  multdiv_issuer #(.TIMEOUT(TO), .MULT_EXC_CODE(4), .DIV_EXC_CODE(5), .EXC_REG(30)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_is_div(op_is_div),
    .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .stall(stall), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy), .dbg_state_o(dbg_state_o)
  );

  // clock / global time limit
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s observed=0x%08h required=0x%08h", tag, obs, exp);
  endtask

  // Behavioural multdiv: signed 32-bit arithmetic, exception on overflow or /0.
  function automatic void mdu_model(input logic [31:0] a, input logic [31:0] b,
                                    input logic is_div, output logic [31:0] res,
                                    output logic exc);
    longint p;
    if (!is_div) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      exc = (p > MAXI) || (p < MINI);
      res = p[31:0];
    end else if (b == 32'd0) begin
      exc = 1'b1;
      res = 32'd0;
    end else begin
      p   = longint'($signed(a)) / longint'($signed(b));
      exc = (p > MAXI);
      res = p[31:0];
    end
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      op_valid       = 1'b0;
      op_a           = $urandom;
      data_resultRDY = 1'($urandom_range(0, 1));
      data_exception = 1'($urandom_range(0, 1));
      data_result    = $urandom;
      #1;
      check("idle_wb_valid", wb_valid, 0);
      check("idle_stall", stall, 0);
      check("idle_busy", busy, 0);
    end
  endtask

  // Drive one operation; RDY arrives rdy_delay cycles after WAIT entry (-1 = never).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic is_div, input int rdy_delay, input logic stale);
    logic [31:0] res;
    logic        exc;
    logic        real_path;
    logic        opnd_ok;
    logic [36:0] e;
    int exp_k, seen_k, stall_cnt, mc, dc, rdy_k;
    mdu_model(a, b, is_div, res, exc);
    real_path = (rdy_delay >= 0) && (rdy_delay <= TO - 1);
    if (real_path && !exc) exp_q.push_back({rd, res});
    else exp_q.push_back({5'd30, is_div ? 32'd5 : 32'd4});
    exp_k     = 3 + (real_path ? rdy_delay : TO - 1);
    rdy_k     = (rdy_delay >= 0) ? 2 + rdy_delay : -10;
    seen_k    = -1;
    stall_cnt = 0;
    mc        = 0;
    dc        = 0;
    opnd_ok   = 1'b1;
    for (int k = 0; k < TO + 20; k++) begin
      @(negedge clock);
      if (k == 0) begin
        op_valid = 1'b1; op_a = a; op_b = b; op_rd = rd; op_is_div = is_div;
      end else begin
        op_valid = 1'($urandom_range(0, 1)); op_a = $urandom; op_b = $urandom;
        op_rd = 5'($urandom); op_is_div = 1'($urandom_range(0, 1));
      end
      data_resultRDY = (k == rdy_k) || (k == 1 && stale);
      data_exception = (k == rdy_k) ? exc : 1'($urandom_range(0, 1));
      data_result    = (k == rdy_k) ? res : $urandom;
      #1;
      if (k == 0) begin
        check("accept_busy", busy, 0);
        check("accept_wb_valid", wb_valid, 0);
      end
      if (k == 1) check("issue_ctrl", {ctrl_MULT, ctrl_DIV}, is_div ? 2'b01 : 2'b10);
      if (k >= 1 && (data_operandA !== a || data_operandB !== b)) opnd_ok = 1'b0;
      if (stall) stall_cnt++;
      if (ctrl_MULT) mc++;
      if (ctrl_DIV) dc++;
      if (wb_valid) begin
        seen_k = k;
        break;
      end
    end
    check("wb_cycle", 32'(seen_k), 32'(exp_k));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (seen_k >= 0) begin
        check("wb_rd", wb_rd, e[36:32]);
        check("wb_data", wb_data, e[31:0]);
      end
    end
    check("stall_cycles", 32'(stall_cnt), 32'(exp_k));
    check("stall_done", stall, 0);
    check("mult_pulses", 32'(mc), is_div ? 0 : 1);
    check("div_pulses", 32'(dc), is_div ? 1 : 0);
    check("operands_stable", opnd_ok, 1);
  endtask

  task automatic reset_mid_wait();
    @(negedge clock);
    op_valid = 1'b1; op_is_div = 1'b0; op_a = 32'd11; op_b = 32'd13; op_rd = 5'd7;
    data_resultRDY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      op_valid = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_wait_busy", busy, 0);
    check("rst_wait_state", dbg_state_o, 0);
    check("rst_wait_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
    check("rst_wait_opnd", data_operandA | data_operandB, 0);
    check("rst_wait_wb", {wb_valid, wb_rd}, 0);
    check("rst_wait_wbdata", wb_data, 0);
    check("rst_wait_stall", stall, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      data_resultRDY = 1'b1; data_result = 32'd143; data_exception = 1'b0;
      #1;
      check("late_rdy_wb", wb_valid, 0);
      check("late_rdy_busy", busy, 0);
    end
    @(negedge clock);
    data_resultRDY = 1'b0;
    #1;
    check("late_rdy_wb", wb_valid, 0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int dly;
    reset = 1'b1; op_valid = 1'b1; op_is_div = 1'b0; op_a = 32'hDEAD_BEEF;
    op_b = 32'h1234_5678; op_rd = 5'd31; data_result = 32'hFFFF_FFFF;
    data_exception = 1'b1; data_resultRDY = 1'b1;
    repeat (3) @(negedge clock);
    op_valid = 1'b0; data_resultRDY = 1'b0;
    #1;
    check("reset_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
    check("reset_opA", data_operandA, 0);
    check("reset_opB", data_operandB, 0);
    check("reset_wb", {wb_valid, wb_rd}, 0);
    check("reset_wbdata", wb_data, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    idle_cycles(2);

    run_op(32'd7, 32'd6, 5'd3, 1'b0, 4, 1'b0);
    idle_cycles(1);
    run_op(32'd100, 32'd0, 5'd8, 1'b1, 2, 1'b0);
    idle_cycles(1);
    run_op(32'h4000_0000, 32'd4, 5'd9, 1'b0, 0, 1'b0);
    run_op(32'd2, 32'd3, 5'd5, 1'b0, 3, 1'b1);
    run_op(32'd50, 32'd7, 5'd12, 1'b1, TO - 1, 1'b0);
    run_op(32'd9, 32'd9, 5'd4, 1'b0, -1, 1'b0);
    run_op(32'd81, 32'd9, 5'd6, 1'b1, TO + 2, 1'b1);
    check("stall_after_timeout", stall, 0);
    idle_cycles(1);

    reset_mid_wait();
    run_op(32'd3, 32'd5, 5'd1, 1'b0, 1, 1'b0);
    run_op(32'hFFFF_FFFE, 32'd9, 5'd2, 1'b0, 2, 1'b0);
    check("b2b_last_data", wb_data, 32'hFFFF_FFEE);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        ra = $urandom; rb = $urandom;
      end else begin
        ra = 32'($signed($urandom_range(0, 400)) - 200);
        rb = 32'($signed($urandom_range(0, 20)) - 10);
      end
      dly = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TO + 3));
      run_op(ra, rb, 5'($urandom), 1'($urandom_range(0, 1)), dly, 1'($urandom_range(0, 1)));
      idle_cycles(int'($urandom_range(0, 2)));
    end

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multdiv_issuer.md
Name: multdiv_issuer

Overview:
Processor-side initiator for the multdiv unit. It sits in the execute stage and detects a mult or div instruction. It latches the operands, issues a single-cycle ctrl_MULT or ctrl_DIV pulse, stalls the pipeline until data_resultRDY, and then presents exactly one writeback. On an exception, that writeback goes to the status register. A watchdog bounds the wait so a hung unit can never deadlock the core.

Parameters:
TIMEOUT, 64, maximum WAIT cycles before the operation is forced to complete with an exception (2..255)
MULT_EXC_CODE, 4, writeback data for a mult exception or mult timeout
DIV_EXC_CODE, 5, writeback data for a div exception or div timeout
EXC_REG, 30, destination register index for exception writebacks

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high reset
op_valid  in  1  X-stage instruction is mult/div; sampled only in IDLE
op_is_div  in  1  1 = div, 0 = mult
op_a  in  32  operand A (rs)
op_b  in  32  operand B (rt)
op_rd  in  5  destination register
ctrl_MULT  out  1  mult start pulse to multdiv
ctrl_DIV  out  1  div start pulse to multdiv
data_operandA  out  32  latched operand A to multdiv
data_operandB  out  32  latched operand B to multdiv
data_result  in  32  multdiv result
data_exception  in  1  multdiv exception flag
data_resultRDY  in  1  multdiv completion
stall  out  1  hold F/D/X stages
wb_valid  out  1  one-cycle writeback strobe
wb_rd  out  5  writeback register
wb_data  out  32  writeback value
busy  out  1  state != IDLE

Behaviour:
- Clock and reset:
  - Single clock domain. All state changes on rising clock edges.
  - reset (sync, high) forces state IDLE.
  - Reset values: ctrl_MULT=0, ctrl_DIV=0, data_operandA=0, data_operandB=0, wb_valid=0, wb_rd=0, wb_data=0, busy=0, watchdog counter=0.
  - Reset in any state, including mid-WAIT, abandons the operation with no writeback. A late data_resultRDY arriving afterwards in IDLE is ignored.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If op_valid=1: latch op_a/op_b into data_operandA/B, latch op_is_div and op_rd, then go to ISSUE.
  - data_resultRDY is ignored in IDLE.
- ISSUE (exactly 1 cycle):
  - Registered output: ctrl_DIV=op_is_div and ctrl_MULT=!op_is_div. Never both high.
  - Watchdog cleared. Go to WAIT.
  - data_resultRDY is ignored this cycle, since it may be stale from the previous operation.
- WAIT:
  - ctrl_MULT=0, ctrl_DIV=0. Watchdog increments each cycle.
  - If data_resultRDY=1:
    - If data_exception=0: wb_data=data_result, wb_rd=latched rd.
    - If data_exception=1: wb_data=DIV_EXC_CODE or MULT_EXC_CODE as appropriate, wb_rd=EXC_REG.
    - Go to DONE.
  - Else, if watchdog reaches TIMEOUT-1: take the exception path, go to DONE.
  - If data_resultRDY=1 in the same cycle the timeout fires, the RDY takes priority and the real result is used.
- DONE (exactly 1 cycle): wb_valid=1, stall=0. Go to IDLE.
- stall (combinational): (IDLE && op_valid) || ISSUE || WAIT.
  - The pipeline therefore advances on the DONE cycle, and op_valid seen in the following IDLE belongs to the next instruction.
- Operand stability:
  - data_operandA/B stay constant from ISSUE through DONE.
  - op_a, op_b, op_rd and op_is_div are not re-sampled outside IDLE; op_valid dropping mid-operation has no effect.
- Latency: op_valid accepted in IDLE at cycle T → ctrl pulse at T+1 → WAIT from T+2 → RDY first seen at cycle W → wb_valid at W+1. Minimum W = T+2.
- Back-to-back: a new op_valid in the IDLE cycle right after DONE is accepted normally. There is one idle cycle between operations.
- wb_rd and wb_data hold their values after DONE until the next DONE or reset. wb_valid is high only in DONE.

Test Plan:
1. Mult result: reset, then op_valid, mult, 7 × 6, rd=3; multdiv returns 42 with RDY=1 at W → one-cycle ctrl_MULT at T+1; wb_valid at W+1 with wb_rd=3, wb_data=42; stall high exactly T..W.
2. Div by zero: div, 100 ÷ 0, rd=8; RDY=1 with exception=1 → wb_rd=30, wb_data=5; ctrl_DIV pulsed once, ctrl_MULT never high.
3. Mult overflow: mult, 0x40000000 × 4; exception=1 → wb_rd=30, wb_data=4.
4. Stale and simultaneous events:
   - Hold data_resultRDY=1 during the ISSUE cycle → ignored, no early writeback.
   - Assert RDY in the same cycle the timeout would fire → real result is written.
5. Timeout with TIMEOUT=8: RDY never asserted → wb_valid exactly 8 cycles after WAIT entry, with wb_rd=30 and the exception code; stall then drops.
6. Reset and back-to-back:
   - Assert reset mid-WAIT → all outputs 0, state IDLE; a following RDY produces no wb_valid.
   - Then two back-to-back mults (3 × 5, then −2 × 9) → wb_data=15 then 0xFFFFFFEE, each with one wb_valid.
